// File: rtl/stack_seq.sv
// stack_seq: 8080 stack-command initiator for the data memory's stack port.
// Keeps a shadow SP, range-checks each access, drives one-cycle memory
// strobes and returns a fixed-latency response (3 cycles after acceptance).
//
// state | meaning
// IDLE  | ready for a command
// ISSUE | memory strobe (if legal) is high, SP/flags update at end
// WAIT  | memory read data valid, response captured at end
// RESP  | rsp_valid pulse
module stack_seq #(
  parameter logic [15:0] STACK_LIMIT = 16'hC000,
  parameter logic [15:0] RESET_SP    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] sp,
  output logic        err_overflow,
  output logic        err_underflow,
  input  logic        err_clear,
  output logic        mem_push,
  output logic        mem_pop,
  output logic        mem_swap,
  output logic        mem_replace_SP,
  output logic [15:0] mem_input_data,
  input  logic [15:0] mem_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_XTHL = 2'd2;
  localparam logic [1:0] OP_SPHL = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] data_q, data_d;
  logic        legal_q, legal_d;
  logic        push_q, push_d;
  logic        pop_q, pop_d;
  logic        swap_q, swap_d;
  logic        repl_q, repl_d;
  logic [15:0] in_data_q, in_data_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  logic [16:0] top;
  logic        push_ok;
  logic        pop_ok;
  logic        cmd_legal;
  logic        accept;
  logic        set_ovf;
  logic        set_udf;

  // Range checks on the effective 17-bit top; sp==0 means the empty stack at 0x10000.
  always_comb begin
    top       = (sp_q == 16'h0000) ? 17'h10000 : {1'b0, sp_q};
    push_ok   = (top - 17'd2) >= {1'b0, STACK_LIMIT};
    pop_ok    = (top + 17'd2) <= 17'h10000;
    cmd_legal = 1'b1;
    case (cmd_op)
      OP_PUSH: cmd_legal = push_ok;
      OP_POP,
      OP_XTHL: cmd_legal = pop_ok;
      default: cmd_legal = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: one cycle per state after acceptance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign accept  = (state_q == S_IDLE) && cmd_valid;
  assign set_ovf = (state_q == S_ISSUE) && !legal_q && (op_q == OP_PUSH);
  assign set_udf = (state_q == S_ISSUE) && !legal_q &&
                   ((op_q == OP_POP) || (op_q == OP_XTHL));

  // Datapath next-state: latch command, strobes, SP update, response capture.
  always_comb begin
    op_d       = op_q;
    data_d     = data_q;
    legal_d    = legal_q;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    swap_d     = 1'b0;
    repl_d     = 1'b0;
    in_data_d  = 16'h0000;
    sp_d       = sp_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    if (accept) begin
      op_d      = cmd_op;
      data_d    = cmd_data;
      legal_d   = cmd_legal;
      push_d    = cmd_legal && (cmd_op == OP_PUSH);
      pop_d     = cmd_legal && (cmd_op == OP_POP);
      swap_d    = cmd_legal && (cmd_op == OP_XTHL);
      repl_d    = cmd_legal && (cmd_op == OP_SPHL);
      in_data_d = cmd_data;
    end

    if (state_q == S_ISSUE && legal_q) begin
      case (op_q)
        OP_PUSH: sp_d = sp_q - 16'd2;
        OP_POP:  sp_d = sp_q + 16'd2;
        OP_SPHL: sp_d = data_q;
        default: sp_d = sp_q;
      endcase
    end

    if (state_q == S_WAIT) begin
      rsp_err_d = !legal_q;
      if (!legal_q)
        rsp_data_d = 16'h0000;
      else if ((op_q == OP_POP) || (op_q == OP_XTHL))
        rsp_data_d = mem_out;
      else
        rsp_data_d = sp_q;
    end

    // A set in the same cycle as err_clear keeps the flag.
    ovf_d = set_ovf | (ovf_q & ~err_clear);
    udf_d = set_udf | (udf_q & ~err_clear);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_PUSH;
      data_q     <= 16'h0000;
      legal_q    <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      swap_q     <= 1'b0;
      repl_q     <= 1'b0;
      in_data_q  <= 16'h0000;
      sp_q       <= RESET_SP;
      rsp_data_q <= 16'h0000;
      rsp_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      op_q       <= op_d;
      data_q     <= data_d;
      legal_q    <= legal_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      swap_q     <= swap_d;
      repl_q     <= repl_d;
      in_data_q  <= in_data_d;
      sp_q       <= sp_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign sp             = sp_q;
  assign err_overflow   = ovf_q;
  assign err_underflow  = udf_q;
  assign mem_push       = push_q;
  assign mem_pop        = pop_q;
  assign mem_swap       = swap_q;
  assign mem_replace_SP = repl_q;
  assign mem_input_data = in_data_q;

endmodule

// File: tb/tb_stack_seq.sv
// Testbench for stack_seq: directed commands, scoreboard queue of expected
// responses popped by an independent monitor, plus a behavioural memory stack.
module tb_stack_seq;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] sp;
  logic        err_overflow;
  logic        err_underflow;
  logic        err_clear;
  logic        mem_push;
  logic        mem_pop;
  logic        mem_swap;
  logic        mem_replace_SP;
  logic [15:0] mem_input_data;
  logic [15:0] mem_out;

  localparam logic [1:0] PUSH = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] XTHL = 2'd2;
  localparam logic [1:0] SPHL = 2'd3;

  // strobe vector order: {push, pop, swap, replace_SP}
  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_PUSH = 4'b1000;
  localparam logic [3:0] S_POP  = 4'b0100;
  localparam logic [3:0] S_SWAP = 4'b0010;
  localparam logic [3:0] S_REPL = 4'b0001;

  int n_chk  = 0;
  int n_fail = 0;

  logic [16:0] exp_q[$];
  logic [3:0]  strobes;
  assign strobes = {mem_push, mem_pop, mem_swap, mem_replace_SP};

  stack_seq dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .sp             (sp),
    .err_overflow   (err_overflow),
    .err_underflow  (err_underflow),
    .err_clear      (err_clear),
    .mem_push       (mem_push),
    .mem_pop        (mem_pop),
    .mem_swap       (mem_swap),
    .mem_replace_SP (mem_replace_SP),
    .mem_input_data (mem_input_data),
    .mem_out        (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory stack port; its pointer has no reset.
  logic [15:0] mem_arr [0:65535];
  logic [15:0] msp = 16'h0000;
  initial mem_out = 16'h0000;
  always @(posedge clk) begin
    if (mem_replace_SP) msp <= mem_input_data;
    else if (mem_push) begin
      mem_arr[msp - 16'd2] <= mem_input_data;
      msp <= msp - 16'd2;
    end else if (mem_pop) begin
      mem_out <= mem_arr[msp];
      msp <= msp + 16'd2;
    end else if (mem_swap) begin
      mem_out <= mem_arr[msp];
      mem_arr[msp] <= mem_input_data;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected rsp_valid", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("rsp_data", {16'h0, rsp_data}, {16'h0, e[15:0]});
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e[16]});
      end
    end
  end

  // Issue one command and follow it through ISSUE/WAIT/RESP.
  task automatic do_cmd(input string nm, input logic [1:0] op, input logic [15:0] data,
                        input logic [3:0] exp_stb, input logic [15:0] exp_rsp,
                        input logic exp_err, input logic [15:0] exp_sp,
                        input logic exp_ovf, input logic exp_udf);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({nm, " cmd_ready idle"}, {31'h0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    exp_q.push_back({exp_err, exp_rsp});
    @(negedge clk); // ISSUE; cmd_valid kept high and must be ignored
    check({nm, " issue strobes"}, {28'h0, strobes}, {28'h0, exp_stb});
    check({nm, " mem_input_data"}, {16'h0, mem_input_data}, {16'h0, data});
    check({nm, " cmd_ready busy"}, {31'h0, cmd_ready}, 32'd0);
    @(negedge clk); // WAIT
    check({nm, " wait strobes"}, {28'h0, strobes}, 32'd0);
    check({nm, " wait mem_input_data"}, {16'h0, mem_input_data}, 32'd0);
    check({nm, " sp"}, {16'h0, sp}, {16'h0, exp_sp});
    check({nm, " err_overflow"}, {31'h0, err_overflow}, {31'h0, exp_ovf});
    check({nm, " err_underflow"}, {31'h0, err_underflow}, {31'h0, exp_udf});
    check({nm, " rsp_valid early"}, {31'h0, rsp_valid}, 32'd0);
    @(negedge clk); // RESP
    cmd_valid = 1'b0;
    check({nm, " rsp_valid"}, {31'h0, rsp_valid}, 32'd1);
    check({nm, " resp strobes"}, {28'h0, strobes}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 16'h0000;
    err_clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset cmd_ready", {31'h0, cmd_ready}, 32'd1);
    check("reset sp", {16'h0, sp}, 32'h0);
    check("reset strobes", {28'h0, strobes}, 32'd0);
    check("reset mem_input_data", {16'h0, mem_input_data}, 32'd0);
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("reset rsp_data", {16'h0, rsp_data}, 32'd0);
    check("reset rsp_err", {31'h0, rsp_err}, 32'd0);
    check("reset err_overflow", {31'h0, err_overflow}, 32'd0);
    check("reset err_underflow", {31'h0, err_underflow}, 32'd0);

    do_cmd("sphl fff0", SPHL, 16'hFFF0, S_REPL, 16'hFFF0, 1'b0, 16'hFFF0, 1'b0, 1'b0);
    do_cmd("push 1234", PUSH, 16'h1234, S_PUSH, 16'hFFEE, 1'b0, 16'hFFEE, 1'b0, 1'b0);
    do_cmd("pop 1234",  POP,  16'h0000, S_POP,  16'h1234, 1'b0, 16'hFFF0, 1'b0, 1'b0);

    pulse_reset();
    check("reset2 sp", {16'h0, sp}, 32'h0);
    do_cmd("sphl 0000", SPHL, 16'h0000, S_REPL, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_cmd("push abcd", PUSH, 16'hABCD, S_PUSH, 16'hFFFE, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    do_cmd("xthl 5555", XTHL, 16'h5555, S_SWAP, 16'hABCD, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    do_cmd("pop 5555",  POP,  16'h0000, S_POP,  16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0);

    do_cmd("pop empty", POP, 16'h0000, S_NONE, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1);
    check("underflow sticky", {31'h0, err_underflow}, 32'd1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("underflow cleared", {31'h0, err_underflow}, 32'd0);

    do_cmd("xthl empty", XTHL, 16'h9999, S_NONE, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;

    do_cmd("sphl c001",  SPHL, 16'hC001, S_REPL, 16'hC001, 1'b0, 16'hC001, 1'b0, 1'b0);
    do_cmd("push limit-1", PUSH, 16'h1111, S_NONE, 16'h0000, 1'b1, 16'hC001, 1'b1, 1'b0);
    do_cmd("sphl c002",  SPHL, 16'hC002, S_REPL, 16'hC002, 1'b0, 16'hC002, 1'b1, 1'b0);
    do_cmd("push limit", PUSH, 16'h7777, S_PUSH, 16'hC000, 1'b0, 16'hC000, 1'b1, 1'b0);
    err_clear = 1'b1;
    @(negedge clk);
    check("overflow cleared", {31'h0, err_overflow}, 32'd0);

    // err_clear held high across a rejected push: set wins at end of ISSUE,
    // then the still-asserted clear removes it one cycle later.
    do_cmd("push clr-race", PUSH, 16'h2222, S_NONE, 16'h0000, 1'b1, 16'hC000, 1'b1, 1'b0);
    check("overflow clr after race", {31'h0, err_overflow}, 32'd0);
    err_clear = 1'b0;

    // Reset during WAIT of a legal POP discards it.
    pulse_reset();
    do_cmd("sphl fff0 b", SPHL, 16'hFFF0, S_REPL, 16'hFFF0, 1'b0, 16'hFFF0, 1'b0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = POP;
    cmd_data  = 16'h0000;
    @(negedge clk);
    check("abort issue mem_pop", {31'h0, mem_pop}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort cmd_ready", {31'h0, cmd_ready}, 32'd1);
    check("abort sp", {16'h0, sp}, 32'h0);
    check("abort rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("abort strobes", {28'h0, strobes}, 32'd0);
    check("abort rsp_data", {16'h0, rsp_data}, 32'd0);
    repeat (5) @(negedge clk);

    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- CPU-side initiator for the data memory's stack port. It drives push/pop/swap/replace_SP strobes and collects the popped word from the memory's registered output.
- Accepts one stack command at a time from the 8080 control unit (PUSH, POP, XTHL, SPHL). It keeps a shadow SP, range-checks every access, and returns a response with fixed latency.

Parameters:
- STACK_LIMIT, 16'hC000: lowest legal stack byte address. A push that would move the top below this is rejected.
- RESET_SP, 16'h0000: shadow SP after reset. 16'h0000 encodes an empty stack with top at 17'h10000.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command (IDLE only)
- cmd_op  in  2  0=PUSH, 1=POP, 2=XTHL (exchange top), 3=SPHL (load SP)
- cmd_data  in  16  word to push, exchange, or load as SP
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  16  POP/XTHL: old top word; PUSH/SPHL: new SP; rejected: 0
- rsp_err  out  1  qualifies rsp_valid; command rejected
- sp  out  16  shadow stack pointer
- err_overflow  out  1  sticky, rejected PUSH
- err_underflow  out  1  sticky, rejected POP/XTHL
- err_clear  in  1  clears both sticky flags
- mem_push, mem_pop, mem_swap, mem_replace_SP  out  1 each  memory stack strobes
- mem_input_data  out  16  data to memory stack port
- mem_out  in  16  memory stack read data, valid the cycle after a pop/swap strobe

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Transitions:
  - IDLE -> ISSUE on cmd_valid && cmd_ready; latch op and data at this edge (E0).
  - ISSUE -> WAIT -> RESP -> IDLE, one cycle each, unconditional.
- cmd_ready = 1 only in IDLE. A command is accepted every 4 cycles at most. cmd_valid outside IDLE is ignored; the initiator must hold it until accepted.
- Effective top T (17 bit) = (sp==0) ? 17'h10000 : {1'b0, sp}. All range checks are unsigned 17-bit.
- Legality, evaluated at E0:
  - PUSH legal iff T-2 >= STACK_LIMIT.
  - POP and XTHL legal iff T+2 <= 17'h10000.
  - SPHL is always legal.
- Strobes are registered outputs, high for exactly the ISSUE cycle, and only for legal commands. At most one strobe is high in any cycle.
  - PUSH: mem_push.
  - POP: mem_pop.
  - XTHL: mem_swap.
  - SPHL: mem_replace_SP.
- mem_input_data = latched cmd_data during ISSUE, 0 otherwise.
- Shadow SP updates at the end of ISSUE, for legal commands only:
  - PUSH: sp-2.
  - POP: sp+2.
  - SPHL: cmd_data.
  - XTHL: unchanged.
  - Arithmetic is 16-bit wrapping, so POP to 0x10000 gives sp=0.
- At the end of WAIT, capture mem_out into rsp_data for legal POP/XTHL; load new sp for PUSH/SPHL; load 0 for rejected commands.
- rsp_valid = 1 for the RESP cycle only, 3 cycles after E0. rsp_data and rsp_err hold until the next response.
- Rejected command:
  - No strobe; sp unchanged; rsp_err=1.
  - err_overflow (PUSH) or err_underflow (POP/XTHL) set at the end of ISSUE.
- Sticky flags: err_clear clears both. A set event in the same cycle wins over the clear.
- Reset values:
  - FSM = IDLE; sp = RESET_SP.
  - All strobes = 0; mem_input_data = 0.
  - rsp_valid = 0; rsp_data = 0; rsp_err = 0.
  - err_overflow = 0; err_underflow = 0.
  - cmd_ready = 1 in the cycle after reset.
- Reset mid-operation: strobes drop at the reset edge and the in-flight command is discarded without a response.
- The memory's own stack pointer has no reset. The control unit must issue SPHL after every reset to resynchronise it with the shadow SP.

Test Plan:
- Reset, then SPHL 16'hFFF0 -> mem_replace_SP high exactly in cycle E0+1; rsp_valid at E0+3 with rsp_data=16'hFFF0, rsp_err=0; sp=16'hFFF0.
- PUSH 16'h1234 then POP -> PUSH gives one mem_push pulse with mem_input_data=16'h1234, sp=16'hFFEE, rsp_data=16'hFFEE. POP gives rsp_data=16'h1234, sp=16'hFFF0.
- From reset (sp=0): PUSH 16'hABCD, then XTHL 16'h5555 -> XTHL has mem_swap pulse, rsp_data=16'hABCD, sp stays 16'hFFFE. A following POP returns 16'h5555 and sp=0.
- POP at sp=0 -> no strobe, rsp_err=1, rsp_data=0, err_underflow=1, sp=0. Assert err_clear with no new error -> flag clears next cycle.
- SPHL 16'hC001, then PUSH -> rejected: no mem_push, err_overflow=1, sp=16'hC001. SPHL 16'hC002, then PUSH -> accepted, sp=16'hC000.
- Assert reset during WAIT of a POP -> no rsp_valid; sp=0; cmd_ready=1 the following cycle. Drive cmd_valid during ISSUE -> ignored, with no second strobe.
